// File: rtl/riio_bias_seq_ctrl.sv
// Power-up sequencer for the EG1D80V bias/bandgap cell: startup pulse, valid wait with timeout,
// settle window, then VBIAS grant; all outputs registered, no backpressure (level/pulse inputs only).
module riio_bias_seq_ctrl #(
    parameter int         STARTUP_CYCLES = 16,
    parameter int         SETTLE_CYCLES  = 64,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [3:0] TRIM_BIAS_RST  = 4'h8,
    parameter logic [4:0] TRIM_CURV_RST  = 5'h10,
    parameter logic [4:0] TRIM_VBG_RST   = 5'h10
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       REQ_EN_I,
    input  logic       REQ_VBIAS_I,
    input  logic       TRIM_LD_I,
    input  logic [3:0] TRIM_BIAS_CFG_I,
    input  logic [4:0] TRIM_CURV_CFG_I,
    input  logic [4:0] TRIM_VBG_CFG_I,
    input  logic       BG_VALID_N_I,
    output logic       EN_O,
    output logic       BG_STARTUP_O,
    output logic       EN_VBIAS_O,
    output logic [3:0] TRIM_BIAS_O,
    output logic [4:0] TRIM_CURV_O,
    output logic [4:0] TRIM_VBG_O,
    output logic       READY_O,
    output logic       TIMEOUT_O,
    output logic [2:0] STATE_O
);

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_STARTUP    = 3'd1,
        ST_WAIT_VALID = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_READY      = 3'd4,
        ST_FAULT      = 3'd5
    } state_t;

    localparam int MAX_A   = (STARTUP_CYCLES > SETTLE_CYCLES) ? STARTUP_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] LD_STARTUP = CW'(STARTUP_CYCLES - 1);
    localparam logic [CW-1:0] LD_SETTLE  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] LD_TIMEOUT = CW'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sync_q;
    logic            vn_s;
    logic            trim_ld_ok;
    logic            en_q, en_d;
    logic            bg_startup_q, bg_startup_d;
    logic            en_vbias_q, en_vbias_d;
    logic            ready_q, ready_d;
    logic            timeout_q, timeout_d;
    logic [3:0]      trim_bias_q, trim_bias_d;
    logic [4:0]      trim_curv_q, trim_curv_d;
    logic [4:0]      trim_vbg_q, trim_vbg_d;

    assign vn_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF:        if (REQ_EN_I) state_d = ST_STARTUP;
            ST_STARTUP:    if (cnt_q == '0) state_d = ST_WAIT_VALID;
            // Valid beats an expiring timeout in the same cycle.
            ST_WAIT_VALID: if (!vn_s) state_d = ST_SETTLE;
                           else if (cnt_q == '0) state_d = ST_FAULT;
            ST_SETTLE:     if (vn_s) state_d = ST_WAIT_VALID;
                           else if (cnt_q == '0) state_d = ST_READY;
            ST_READY:      if (vn_s) state_d = ST_WAIT_VALID;
                           else if (TRIM_LD_I) state_d = ST_SETTLE;
            ST_FAULT:      state_d = ST_FAULT;
            default:       state_d = ST_OFF;
        endcase
        if (!REQ_EN_I) state_d = ST_OFF;
    end

    always_comb begin
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
        if (state_d != state_q) begin
            unique case (state_d)
                ST_STARTUP:    cnt_d = LD_STARTUP;
                ST_WAIT_VALID: cnt_d = LD_TIMEOUT;
                ST_SETTLE:     cnt_d = LD_SETTLE;
                default:       cnt_d = '0;
            endcase
        end
    end

    always_comb begin
        trim_ld_ok   = TRIM_LD_I && ((state_q == ST_OFF) || (state_q == ST_READY));
        trim_bias_d  = trim_ld_ok ? TRIM_BIAS_CFG_I : trim_bias_q;
        trim_curv_d  = trim_ld_ok ? TRIM_CURV_CFG_I : trim_curv_q;
        trim_vbg_d   = trim_ld_ok ? TRIM_VBG_CFG_I  : trim_vbg_q;
        en_d         = (state_d == ST_STARTUP) || (state_d == ST_WAIT_VALID) ||
                       (state_d == ST_SETTLE)  || (state_d == ST_READY);
        bg_startup_d = (state_d == ST_STARTUP);
        ready_d      = (state_d == ST_READY);
        en_vbias_d   = (state_d == ST_READY) && REQ_VBIAS_I;
        timeout_d    = timeout_q;
        if ((state_q == ST_OFF) && (state_d == ST_STARTUP)) timeout_d = 1'b0;
        if ((state_q == ST_WAIT_VALID) && (state_d == ST_FAULT)) timeout_d = 1'b1;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            sync_q       <= 2'b11;
            en_q         <= 1'b0;
            bg_startup_q <= 1'b0;
            en_vbias_q   <= 1'b0;
            ready_q      <= 1'b0;
            timeout_q    <= 1'b0;
            trim_bias_q  <= TRIM_BIAS_RST;
            trim_curv_q  <= TRIM_CURV_RST;
            trim_vbg_q   <= TRIM_VBG_RST;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_q       <= {sync_q[0], BG_VALID_N_I};
            en_q         <= en_d;
            bg_startup_q <= bg_startup_d;
            en_vbias_q   <= en_vbias_d;
            ready_q      <= ready_d;
            timeout_q    <= timeout_d;
            trim_bias_q  <= trim_bias_d;
            trim_curv_q  <= trim_curv_d;
            trim_vbg_q   <= trim_vbg_d;
        end
    end

    assign EN_O         = en_q;
    assign BG_STARTUP_O = bg_startup_q;
    assign EN_VBIAS_O   = en_vbias_q;
    assign READY_O      = ready_q;
    assign TIMEOUT_O    = timeout_q;
    assign TRIM_BIAS_O  = trim_bias_q;
    assign TRIM_CURV_O  = trim_curv_q;
    assign TRIM_VBG_O   = trim_vbg_q;
    assign STATE_O      = state_q;

endmodule

// File: tb/tb_riio_bias_seq_ctrl.sv
// Directed bench for riio_bias_seq_ctrl: power-up, VBIAS grant, timeout, glitch, trim and reset cases.
module tb_riio_bias_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       req_en;
    logic       req_vbias;
    logic       trim_ld;
    logic [3:0] trim_bias_cfg;
    logic [4:0] trim_curv_cfg;
    logic [4:0] trim_vbg_cfg;
    logic       bg_valid_n;
    logic       en_o;
    logic       bg_startup_o;
    logic       en_vbias_o;
    logic [3:0] trim_bias_o;
    logic [4:0] trim_curv_o;
    logic [4:0] trim_vbg_o;
    logic       ready_o;
    logic       timeout_o;
    logic [2:0] state_o;

    int vectors;
    int miscompares;
    int early;

    riio_bias_seq_ctrl dut (
        .CLK_I           (clk),
        .RST_I           (rst),
        .REQ_EN_I        (req_en),
        .REQ_VBIAS_I     (req_vbias),
        .TRIM_LD_I       (trim_ld),
        .TRIM_BIAS_CFG_I (trim_bias_cfg),
        .TRIM_CURV_CFG_I (trim_curv_cfg),
        .TRIM_VBG_CFG_I  (trim_vbg_cfg),
        .BG_VALID_N_I    (bg_valid_n),
        .EN_O            (en_o),
        .BG_STARTUP_O    (bg_startup_o),
        .EN_VBIAS_O      (en_vbias_o),
        .TRIM_BIAS_O     (trim_bias_o),
        .TRIM_CURV_O     (trim_curv_o),
        .TRIM_VBG_O      (trim_vbg_o),
        .READY_O         (ready_o),
        .TIMEOUT_O       (timeout_o),
        .STATE_O         (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        early = 0;
        rst = 1'b1;
        req_en = 1'b0;
        req_vbias = 1'b0;
        trim_ld = 1'b0;
        trim_bias_cfg = 4'h0;
        trim_curv_cfg = 5'h00;
        trim_vbg_cfg = 5'h00;
        bg_valid_n = 1'b1;
        repeat (3) tick();

        check("rst_state",   16'(state_o), 16'd0);
        check("rst_en",      16'(en_o), 16'd0);
        check("rst_bg",      16'(bg_startup_o), 16'd0);
        check("rst_vbias",   16'(en_vbias_o), 16'd0);
        check("rst_ready",   16'(ready_o), 16'd0);
        check("rst_timeout", 16'(timeout_o), 16'd0);
        check("rst_tbias",   16'(trim_bias_o), 16'h8);
        check("rst_tcurv",   16'(trim_curv_o), 16'h10);
        check("rst_tvbg",    16'(trim_vbg_o), 16'h10);

        // Power-up: startup pulse of 16 clocks
        rst = 1'b0;
        req_en = 1'b1;
        tick();
        check("up_state1", 16'(state_o), 16'd1);
        check("up_bg1",    16'(bg_startup_o), 16'd1);
        check("up_en1",    16'(en_o), 16'd1);
        repeat (15) tick();
        check("up_bg16",   16'(bg_startup_o), 16'd1);
        tick();
        check("up_bg17",   16'(bg_startup_o), 16'd0);
        check("up_state2", 16'(state_o), 16'd2);

        // Valid arrives 5 clocks after startup; READY 67 clocks after the edge
        repeat (5) tick();
        bg_valid_n = 1'b0;
        repeat (2) tick();
        check("sync_state2", 16'(state_o), 16'd2);
        tick();
        check("sync_state3", 16'(state_o), 16'd3);
        repeat (63) tick();
        check("settle_rdy0", 16'(ready_o), 16'd0);
        tick();
        check("settle_rdy1", 16'(ready_o), 16'd1);
        check("settle_st4",  16'(state_o), 16'd4);

        // VBIAS grant with one clock of latency
        req_vbias = 1'b1;
        check("vbias_pre",  16'(en_vbias_o), 16'd0);
        tick();
        check("vbias_on",   16'(en_vbias_o), 16'd1);

        // Valid lost: READY and VBIAS drop together 3 clocks later
        bg_valid_n = 1'b1;
        repeat (2) tick();
        check("loss_rdy_hold", 16'(ready_o), 16'd1);
        tick();
        check("loss_rdy",   16'(ready_o), 16'd0);
        check("loss_vbias", 16'(en_vbias_o), 16'd0);
        check("loss_state", 16'(state_o), 16'd2);
        check("loss_en",    16'(en_o), 16'd1);

        // Glitch during settle: low 10, high 1, low again
        bg_valid_n = 1'b0;
        repeat (10) tick();
        bg_valid_n = 1'b1;
        tick();
        bg_valid_n = 1'b0;
        tick();
        check("glitch_st_a", 16'(state_o), 16'd3);
        tick();
        check("glitch_st_b", 16'(state_o), 16'd2);
        tick();
        check("glitch_st_c", 16'(state_o), 16'd3);
        for (int i = 0; i < 63; i++) begin
            tick();
            if (ready_o !== 1'b0) early++;
        end
        check("glitch_early", 16'(early), 16'd0);
        tick();
        check("glitch_rdy", 16'(ready_o), 16'd1);
        check("glitch_vb",  16'(en_vbias_o), 16'd1);

        // Trim load in READY re-enters a full settle window
        trim_ld = 1'b1;
        trim_bias_cfg = 4'h3;
        trim_curv_cfg = 5'h1F;
        trim_vbg_cfg = 5'h00;
        tick();
        trim_ld = 1'b0;
        check("trim_bias", 16'(trim_bias_o), 16'h3);
        check("trim_curv", 16'(trim_curv_o), 16'h1F);
        check("trim_vbg",  16'(trim_vbg_o), 16'h00);
        check("trim_rdy0", 16'(ready_o), 16'd0);
        check("trim_vb0",  16'(en_vbias_o), 16'd0);
        check("trim_st3",  16'(state_o), 16'd3);
        repeat (63) tick();
        check("trim_rdy_hold", 16'(ready_o), 16'd0);
        tick();
        check("trim_rdy1", 16'(ready_o), 16'd1);

        // Trim load together with REQ_EN low: both take effect
        trim_ld = 1'b1;
        req_en = 1'b0;
        trim_bias_cfg = 4'h9;
        trim_curv_cfg = 5'h05;
        trim_vbg_cfg = 5'h06;
        tick();
        trim_ld = 1'b0;
        check("off_state", 16'(state_o), 16'd0);
        check("off_tbias", 16'(trim_bias_o), 16'h9);
        check("off_tvbg",  16'(trim_vbg_o), 16'h06);
        check("off_rdy",   16'(ready_o), 16'd0);
        check("off_en",    16'(en_o), 16'd0);

        // Trim load ignored in STARTUP
        req_en = 1'b1;
        tick();
        trim_ld = 1'b1;
        trim_bias_cfg = 4'h1;
        trim_curv_cfg = 5'h02;
        trim_vbg_cfg = 5'h03;
        tick();
        trim_ld = 1'b0;
        check("st_trim_bias", 16'(trim_bias_o), 16'h9);
        check("st_trim_curv", 16'(trim_curv_o), 16'h05);
        check("st_trim_vbg",  16'(trim_vbg_o), 16'h06);
        check("st_state",     16'(state_o), 16'd1);

        // Synchronous reset mid-STARTUP
        rst = 1'b1;
        bg_valid_n = 1'b1;
        tick();
        check("mrst_state", 16'(state_o), 16'd0);
        check("mrst_en",    16'(en_o), 16'd0);
        check("mrst_bg",    16'(bg_startup_o), 16'd0);
        check("mrst_tbias", 16'(trim_bias_o), 16'h8);
        check("mrst_tcurv", 16'(trim_curv_o), 16'h10);
        rst = 1'b0;

        // Timeout: valid never arrives
        tick();
        check("to_state1", 16'(state_o), 16'd1);
        repeat (16) tick();
        check("to_state2", 16'(state_o), 16'd2);
        repeat (1023) tick();
        check("to_wait_hold", 16'(state_o), 16'd2);
        tick();
        check("to_fault",   16'(state_o), 16'd5);
        check("to_flag",    16'(timeout_o), 16'd1);
        check("to_en",      16'(en_o), 16'd0);
        tick();
        check("to_fault_hold", 16'(state_o), 16'd5);
        req_en = 1'b0;
        tick();
        check("to_off",     16'(state_o), 16'd0);
        check("to_sticky",  16'(timeout_o), 16'd1);

        // Trim load in OFF, then retry clears the timeout flag
        trim_ld = 1'b1;
        trim_bias_cfg = 4'h7;
        trim_curv_cfg = 5'h0A;
        trim_vbg_cfg = 5'h15;
        tick();
        trim_ld = 1'b0;
        check("offld_bias", 16'(trim_bias_o), 16'h7);
        check("offld_vbg",  16'(trim_vbg_o), 16'h15);
        req_en = 1'b1;
        tick();
        check("retry_state", 16'(state_o), 16'd1);
        check("retry_to",    16'(timeout_o), 16'd0);
        check("retry_bg",    16'(bg_startup_o), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
